dcache_ctrl: RTL and testbench

L1 data cache controller for the MEM stage of the pipelined CPU. It is a direct-mapped, write-back, write-allocate cache between the EX/MEM register and the 256-bit main memory. It returns load data to the MEM/WB register. On any miss it asserts a stall that drives `halt_i` on every pipeline register, so the whole pipe freezes until the line is resident.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/dcache_ctrl_if.sv | 35 +++
 rtl/dcache_sram.sv | 77 +++++++
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared widths, FSM state type and line-address helper for the
//             L1 data cache controller and its storage arrays.
//  Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

  localparam int TAG_W      = 22;
  localparam int IDX_W      = 5;
  localparam int OFS_W      = 5;
  localparam int WORD_SEL_W = 3;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } dcache_state_t;

  // Byte address of the first byte of a line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFS_W{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl_if
//  Purpose  : CPU-side (p1_*) and memory-side (mem_*) bus of the data cache.
//  Ports    : slave  - cache controller view
//             master - pipeline/memory (environment) view
//  Revision : 1.0  initial release
// ============================================================================
interface dcache_ctrl_if #(
  parameter int LINE_BITS = 256
);
  logic                 p1_req_i;
  logic                 p1_write_i;
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_sram
//  Purpose  : Tag, valid, dirty and data arrays of the direct-mapped cache.
//  Ports    : clk_i/rst_i      clock, sync active-high reset (valid/dirty only)
//             rd_*             asynchronous read of one line
//             line_*           full-line write (refill): sets valid, clears dirty
//             word_*           single-word write (store hit): sets dirty
//  Revision : 1.0  initial release
// ============================================================================
module dcache_sram
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_line_o,
  input  logic                  line_we_i,
  input  logic [IDX_W-1:0]      line_idx_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_BITS-1:0]  line_data_i,
  input  logic                  word_we_i,
  input  logic [IDX_W-1:0]      word_idx_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_data_i
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_line_o  = data_mem[rd_idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[line_idx_i] = 1'b1;
      dirty_d[line_idx_i] = 1'b0;
    end
    if (word_we_i) begin
      dirty_d[word_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_mem[line_idx_i]  <= line_tag_i;
      data_mem[line_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_mem[word_idx_i][{word_sel_i, 5'b00000} +: WORD_W] <= word_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Direct-mapped, write-back, write-allocate L1 data cache
//             controller. Hits complete with zero stall; misses freeze the
//             pipe while the victim is written back (if dirty) and the line
//             is refilled, after which the held access replays as a hit.
//  Ports    : clk_i, rst_i  clock and sync active-high reset
//             bus           dcache_ctrl_if.slave (p1_* CPU side, mem_* memory)
//  Revision : 1.0  initial release
// ============================================================================
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_ctrl_if.slave bus
);

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  line_we, word_we;
  logic                  unused_byte_ofs;

  dcache_state_t         state_q, state_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]  mem_data_q, mem_data_d;

  assign req_tag         = bus.p1_addr_i[31:10];
  assign req_idx         = bus.p1_addr_i[9:5];
  assign req_word        = bus.p1_addr_i[4:2];
  assign unused_byte_ofs = ^bus.p1_addr_i[1:0];

  // The arrays are always read at the live request index: p1_* is held
  // stable during a miss, so this also yields the victim line at detection.
  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (req_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .line_we_i   (line_we),
    .line_idx_i  (idx_q),
    .line_tag_i  (tag_q),
    .line_data_i (bus.mem_data_i),
    .word_we_i   (word_we),
    .word_idx_i  (req_idx),
    .word_sel_i  (req_word),
    .word_data_i (bus.p1_data_i)
  );

  assign hit     = rd_valid & (rd_tag == req_tag);
  assign word_we = (state_q == IDLE) & bus.p1_req_i & bus.p1_write_i & hit;
  // An ack that coincides with reset must not install a line.
  assign line_we = (state_q == REFILL) & bus.mem_ack_i & ~rst_i;

  assign bus.p1_stall_o   = (state_q != IDLE) | (bus.p1_req_i & ~hit);
  assign bus.p1_data_o    = rd_line[{req_word, 5'b00000} +: WORD_W];
  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  // Memory outputs are computed for the next state so they stay registered.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.p1_req_i && !hit) begin
          tag_d    = req_tag;
          idx_d    = req_idx;
          mem_en_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d    = WRITEBACK;
            mem_wr_d   = 1'b1;
            mem_addr_d = line_addr(rd_tag, req_idx);
            mem_data_d = rd_line;
          end else begin
            state_d    = REFILL;
            mem_addr_d = line_addr(req_tag, req_idx);
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_d = ALLOCATE;
        end else begin
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = mem_addr_q;
          mem_data_d = mem_data_q;
        end
      end
      ALLOCATE: begin
        state_d    = REFILL;
        mem_en_d   = 1'b1;
        mem_addr_d = line_addr(tag_q, idx_q);
      end
      REFILL: begin
        if (bus.mem_ack_i) begin
          state_d = IDLE;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = line_addr(tag_q, idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Self-checking bench for dcache_ctrl: directed vector table,
//             reset/ack corner sequences and randomized accesses checked
//             against a transparent-memory reference with a tag/valid/dirty
//             directory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.LINE_BITS(256)) bus ();

  dcache_ctrl #(
    .NUM_LINES (32),
    .LINE_BITS (256)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory responder and manual override for the corner sequences.
  int           lat;
  bit           auto_ack;
  logic         resp_ack;
  logic [255:0] resp_data;
  logic         man_ack;
  logic [255:0] man_data;
  int           en_cnt;

  assign bus.mem_ack_i  = auto_ack ? resp_ack  : man_ack;
  assign bus.mem_data_i = auto_ack ? resp_data : man_data;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } xfer_t;
  xfer_t log_q[$];

  logic [255:0] resp_mem [logic [26:0]];
  logic [31:0]  arch_mem [logic [29:0]];

  bit          m_valid [32];
  bit          m_dirty [32];
  logic [21:0] m_tag   [32];

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    if (wa == 30'h10) return 32'hDEAD_BEEF;
    return {wa[15:0], 16'hA5C3} ^ {2'b00, wa};
  endfunction

  function automatic logic [255:0] resp_line(input logic [26:0] la);
    logic [255:0] l;
    if (resp_mem.exists(la)) return resp_mem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la, 3'(w)});
    return l;
  endfunction

  function automatic logic [31:0] arch_word(input logic [29:0] wa);
    if (arch_mem.exists(wa)) return arch_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] arch_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word({la, 3'(w)});
    return l;
  endfunction

  always @(negedge clk) begin
    if (bus.mem_enable_o && !rst) begin
      en_cnt = en_cnt + 1;
      if (auto_ack && en_cnt >= lat) begin
        resp_ack = 1'b1;
        en_cnt   = 0;
        if (bus.mem_write_o) begin
          resp_mem[bus.mem_addr_o[31:5]] = bus.mem_data_o;
          log_q.push_back('{1'b1, bus.mem_addr_o, bus.mem_data_o});
        end else begin
          resp_data = resp_line(bus.mem_addr_o[31:5]);
          log_q.push_back('{1'b0, bus.mem_addr_o, resp_data});
        end
      end else begin
        resp_ack = 1'b0;
      end
    end else begin
      resp_ack = 1'b0;
      en_cnt   = 0;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one access from issue to completion and checks it against the model.
  task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output int stall_cyc, output logic [31:0] rdata);
    logic [4:0]   idx;
    logic [21:0]  tag;
    bit           hit, dirty_vict, done;
    int           exp_stall, exp_low, low_cyc, exp_n;
    logic [31:0]  vict_addr;
    logic [255:0] vict_line;
    idx        = addr[9:5];
    tag        = addr[31:10];
    hit        = m_valid[idx] && (m_tag[idx] == tag);
    dirty_vict = !hit && m_valid[idx] && m_dirty[idx];
    exp_stall  = hit ? 0 : (dirty_vict ? 2*lat + 2 : lat + 1);
    exp_low    = hit ? 0 : (dirty_vict ? 2 : 1);
    exp_n      = hit ? 0 : (dirty_vict ? 2 : 1);
    vict_addr  = {m_tag[idx], idx, 5'b00000};
    vict_line  = arch_line(vict_addr[31:5]);

    log_q.delete();
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = wr;
    bus.p1_addr_i  = addr;
    bus.p1_data_i  = wdata;
    stall_cyc = 0;
    low_cyc   = 0;
    done      = 1'b0;
    rdata     = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.p1_stall_o) begin
        stall_cyc++;
        if (!bus.mem_enable_o) low_cyc++;
        @(posedge clk); #1;
      end else begin
        done  = 1'b1;
        rdata = bus.p1_data_o;
      end
    end
    check("access_completes", 256'(done), 256'd1);
    @(posedge clk); #1;
    bus.p1_req_i = 1'b0;

    check("stall_cycles", stall_cyc, exp_stall);
    check("mem_idle_while_stalled", low_cyc, exp_low);
    if (!wr) check("load_data", rdata, arch_word(addr[31:2]));
    check("traffic_count", log_q.size(), exp_n);
    if (dirty_vict && log_q.size() == 2) begin
      check("wb_is_write", 256'(log_q[0].wr), 256'd1);
      check("wb_addr", log_q[0].addr, vict_addr);
      check("wb_data", log_q[0].data, vict_line);
    end
    if (!hit && log_q.size() > 0) begin
      check("refill_is_read", 256'(log_q[log_q.size()-1].wr), 256'd0);
      check("refill_addr", log_q[log_q.size()-1].addr, {addr[31:5], 5'b00000});
    end

    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      arch_mem[addr[31:2]] = wdata;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_rf_addr;
    logic [31:0] exp_wb_w1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          st;
    logic [31:0] rd, wb_a, rf_a, wb_w1;
    logic [31:0] ra;

    vecs[0] = '{1'b0, 32'h040, 32'h0,           11, 32'hDEAD_BEEF,   NONE,   32'h040, 32'h0};
    vecs[1] = '{1'b0, 32'h040, 32'h0,            0, 32'hDEAD_BEEF,   NONE,   NONE,    32'h0};
    vecs[2] = '{1'b1, 32'h044, 32'h1234_5678,    0, 32'h0,           NONE,   NONE,    32'h0};
    vecs[3] = '{1'b0, 32'h044, 32'h0,            0, 32'h1234_5678,   NONE,   NONE,    32'h0};
    vecs[4] = '{1'b0, 32'h440, 32'h0,           22, init_word(30'h110), 32'h040, 32'h440, 32'h1234_5678};
    vecs[5] = '{1'b1, 32'h084, 32'hCAFE_F00D,   11, 32'h0,           NONE,   32'h080, 32'h0};
    vecs[6] = '{1'b0, 32'h084, 32'h0,            0, 32'hCAFE_F00D,   NONE,   NONE,    32'h0};
    vecs[7] = '{1'b0, 32'h480, 32'h0,           22, init_word(30'h120), 32'h080, 32'h480, 32'hCAFE_F00D};

    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    rst = 1'b1;
    lat = 10;
    auto_ack  = 1'b1;
    resp_ack  = 1'b0;
    resp_data = '0;
    man_ack   = 1'b0;
    man_data  = '0;
    en_cnt    = 0;
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = '0;
    bus.p1_data_i  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_stall", 256'(bus.p1_stall_o), 256'd0);
    check("reset_mem_enable", 256'(bus.mem_enable_o), 256'd0);
    check("reset_mem_write", 256'(bus.mem_write_o), 256'd0);
    check("reset_mem_addr", bus.mem_addr_o, 256'd0);
    check("reset_mem_data", bus.mem_data_o, 256'd0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rd);
      check($sformatf("vec%0d_stall", i), st, vecs[i].exp_stall);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      wb_a  = NONE;
      rf_a  = NONE;
      wb_w1 = '0;
      foreach (log_q[k]) begin
        if (log_q[k].wr) begin
          wb_a  = log_q[k].addr;
          wb_w1 = log_q[k].data[63:32];
        end else begin
          rf_a = log_q[k].addr;
        end
      end
      check($sformatf("vec%0d_wb_addr", i), wb_a, vecs[i].exp_wb_addr);
      check($sformatf("vec%0d_rf_addr", i), rf_a, vecs[i].exp_rf_addr);
      if (vecs[i].exp_wb_addr != NONE) check($sformatf("vec%0d_wb_word1", i), wb_w1, vecs[i].exp_wb_w1);
    end

    // Reset in the middle of a refill, then a late ack.
    auto_ack = 1'b0;
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = 32'h100;
    repeat (3) @(negedge clk);
    check("mid_refill_enable", 256'(bus.mem_enable_o), 256'd1);
    check("mid_refill_write", 256'(bus.mem_write_o), 256'd0);
    check("mid_refill_addr", bus.mem_addr_o, 256'h100);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.p1_req_i = 1'b0;
    @(negedge clk);
    check("after_reset_enable", 256'(bus.mem_enable_o), 256'd0);
    check("after_reset_stall", 256'(bus.p1_stall_o), 256'd0);
    @(posedge clk); #1;
    man_ack  = 1'b1;
    man_data = {8{32'h5555_AAAA}};
    @(negedge clk);
    check("late_ack_enable", 256'(bus.mem_enable_o), 256'd0);
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    check("late_ack_enable_next", 256'(bus.mem_enable_o), 256'd0);
    check("late_ack_stall", 256'(bus.p1_stall_o), 256'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    auto_ack = 1'b1;
    run_access(1'b0, 32'h040, 32'h0, st, rd);
    check("post_reset_0x40_stall", st, 11);
    run_access(1'b0, 32'h100, 32'h0, st, rd);
    check("post_reset_0x100_data", rd, init_word(30'h40));

    // Ack pulse in IDLE with no request pending.
    auto_ack = 1'b0;
    man_ack  = 1'b1;
    man_data = {8{32'h0BAD_0BAD}};
    @(negedge clk);
    check("idle_ack_enable", 256'(bus.mem_enable_o), 256'd0);
    check("idle_ack_stall", 256'(bus.p1_stall_o), 256'd0);
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_enable_next", 256'(bus.mem_enable_o), 256'd0);
    @(posedge clk); #1;
    auto_ack = 1'b1;
    run_access(1'b0, 32'h040, 32'h0, st, rd);
    check("idle_ack_hit_stall", st, 0);
    check("idle_ack_hit_data", rd, 32'hDEAD_BEEF);

    // Randomized accesses over a few conflicting tags and indices.
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 4);
      ra  = {22'(22'h100 + $urandom_range(0, 2)), 5'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 2'b00};
      run_access(1'($urandom_range(0, 1)), ra, $urandom, st, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
